dispatch_buffer: RTL and testbench
==================================

# dispatch_buffer

Parametrised in-order dispatch buffer between the decode stage and the functional units (ALU, MUL, MEM, ...). It accepts one decoded instruction per cycle, allocates its ROB tail ID, holds it in a DEPTH-entry FIFO while it captures missing source operands from a result broadcast, and issues the head entry to its functional unit once both operands are ready and the unit is not stalled. This replaces the single-slot stall-in-decode scheme: it adds buffering, tag-based wakeup, a configurable unit count and an explicit branch flush.

## Interface
- REG_ADDRESS_SIZE, 5, destination register address width
- REG_SIZE, 32, operand/result width
- ID_SIZE, 4, ROB ID (tag) width
- DEPTH, 4, buffer entries, power of two, ≥2
- NUM_FU, 3, functional units; bit 0 ALU, 1 MUL, 2 MEM
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low
- in_valid  input  1  decoded instruction present
- in_ready  output  1  buffer accepts this cycle
- in_fu  input  NUM_FU  one-hot target unit
- in_op, in_w, in_b  input  1 each  opcode bit, register write, branch
- in_dest  input  REG_ADDRESS_SIZE  destination register
- in_operand1, in_operand2  input  REG_SIZE  source values (valid when no dependency)
- in_dep1, in_dep2  input  1  operand waits on an in-flight result
- in_tag1, in_tag2  input  ID_SIZE  ROB ID producing that operand
- rob_stall  input  1  ROB full; blocks allocation
- tail  output  ID_SIZE  ROB ID assigned to the instruction accepted this cycle
- wb_valid  input  1  result broadcast
- wb_id  input  ID_SIZE  ROB ID of the broadcast result
- wb_value  input  REG_SIZE  broadcast result value
- fu_stall  input  NUM_FU  per-unit busy
- out_valid  output  1  head entry issues this cycle
- out_fu  output  NUM_FU  one-hot unit of issuing entry
- out_op, out_w, out_b  output  1 each  issuing entry fields
- out_dest  output  REG_ADDRESS_SIZE  issuing entry destination
- out_operand1, out_operand2  output  REG_SIZE  resolved operands
- out_id  output  ID_SIZE  issuing entry ROB ID
- take_branch  input  1  flush all buffered, not-yet-issued entries

## Operation
- Storage: DEPTH entries, head/tail pointers log2(DEPTH) bits plus occupancy count 0..DEPTH.
- in_ready = (count != DEPTH) && !rob_stall && !take_branch. Accept = in_valid && in_ready.
- On accept: entry written at tail pointer with tag = tail; each operand stored with a pending flag equal to in_depN; tail increments by 1 mod 2^ID_SIZE.
- Wakeup: every cycle, each valid entry with pending operand N and tag N == wb_id while wb_valid captures wb_value and clears pending. A match against an instruction being accepted in the same cycle is captured at enqueue (stored not pending).
- Issue: out_valid = count != 0 && head has no pending operand && !(|(head.fu & fu_stall)) && !take_branch. On out_valid the head pointer advances. No out-of-order issue.
- out_* fields driven from the head entry whenever count != 0, else zero.
- Flush: take_branch clears count, head and tail pointers; no accept or issue that cycle; ROB tail counter holds its value.
- Simultaneous accept and issue: count unchanged, both pointers advance.

## Timing
- Reset (asynchronous, while reset is low): count, pointers, tail and all entry valid/pending flags 0; out_valid 0; out_* 0; in_ready 0.
- After reset deassertion in_ready = !rob_stall.
- Accept-to-issue latency minimum 1 cycle (entry accepted at edge N is issuable during cycle N+1).
- Wakeup-to-issue: operand captured at edge N; head may issue during cycle N+1. No combinational forwarding of wb_value to out_operand.
- in_ready, out_valid are combinational from registered state and the stall/flush inputs; no combinational path from in_valid to in_ready.
- Full: a full buffer refuses input even if the head issues that cycle.

## Structure
- Shared package/header dispatch_defs: FU bit indices (FU_ALU=0, FU_MUL=1, FU_MEM=2), entry field widths and the entry record layout.
- Sub-module dispatch_entry: one slot holding fields, two operand/pending pairs and the wakeup compare logic; instantiated DEPTH times via generate.

## Test plan
- Reset mid-operation: 3 entries buffered, reset low -> out_valid 0, tail 0, in_ready 0 immediately; after release in_ready 1.
- No dependencies: accept ALU op operands 5,7 at edge 1 -> out_valid 1 in cycle 2, out_operand1=5, out_operand2=7, out_id=0, tail=1.
- Wakeup: accept with in_dep2=1, in_tag2=3; wb_valid, wb_id=3, wb_value=0x2A two cycles later -> issue the following cycle with out_operand2=0x2A.
- Same-cycle wakeup and enqueue, tag match -> stored resolved, issues next cycle.
- Fill DEPTH=4 with MUL ops, fu_stall[1]=1 -> in_ready 0; drop stall -> one issue per cycle in order, IDs 0,1,2,3.
- take_branch with 2 entries -> out_valid 0, count 0; next accept gets the held tail value; tail ID wraps 15->0 after 16 accepts.

Source files
------------

// File: rtl/dispatch_buffer_pkg.sv
// Shared definitions for the dispatch buffer: FU bit positions, default widths
// and the packed control-field record carried by each entry.
package dispatch_buffer_pkg;

  localparam int unsigned FU_ALU = 0;
  localparam int unsigned FU_MUL = 1;
  localparam int unsigned FU_MEM = 2;

  localparam int unsigned DEF_REG_ADDRESS_SIZE = 5;
  localparam int unsigned DEF_REG_SIZE         = 32;
  localparam int unsigned DEF_ID_SIZE          = 4;
  localparam int unsigned DEF_DEPTH            = 4;
  localparam int unsigned DEF_NUM_FU           = 3;

  // Single-bit instruction attributes travelling with every entry.
  typedef struct packed {
    logic op;
    logic w;
    logic b;
  } ctrl_t;

endpackage

// File: rtl/dispatch_buffer_if.sv
// Decode/writeback/FU-side signal bundle of the dispatch buffer.
interface dispatch_buffer_if
  import dispatch_buffer_pkg::*;
#(
  parameter int unsigned REG_ADDRESS_SIZE = DEF_REG_ADDRESS_SIZE,
  parameter int unsigned REG_SIZE         = DEF_REG_SIZE,
  parameter int unsigned ID_SIZE          = DEF_ID_SIZE,
  parameter int unsigned NUM_FU           = DEF_NUM_FU
) ();

  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_FU-1:0]           in_fu;
  logic                        in_op;
  logic                        in_w;
  logic                        in_b;
  logic [REG_ADDRESS_SIZE-1:0] in_dest;
  logic [REG_SIZE-1:0]         in_operand1;
  logic [REG_SIZE-1:0]         in_operand2;
  logic                        in_dep1;
  logic                        in_dep2;
  logic [ID_SIZE-1:0]          in_tag1;
  logic [ID_SIZE-1:0]          in_tag2;
  logic                        rob_stall;
  logic [ID_SIZE-1:0]          tail;
  logic                        wb_valid;
  logic [ID_SIZE-1:0]          wb_id;
  logic [REG_SIZE-1:0]         wb_value;
  logic [NUM_FU-1:0]           fu_stall;
  logic                        out_valid;
  logic [NUM_FU-1:0]           out_fu;
  logic                        out_op;
  logic                        out_w;
  logic                        out_b;
  logic [REG_ADDRESS_SIZE-1:0] out_dest;
  logic [REG_SIZE-1:0]         out_operand1;
  logic [REG_SIZE-1:0]         out_operand2;
  logic [ID_SIZE-1:0]          out_id;
  logic                        take_branch;

  modport master (
    output in_valid, in_fu, in_op, in_w, in_b, in_dest, in_operand1, in_operand2,
           in_dep1, in_dep2, in_tag1, in_tag2, rob_stall, wb_valid, wb_id, wb_value,
           fu_stall, take_branch,
    input  in_ready, tail, out_valid, out_fu, out_op, out_w, out_b, out_dest,
           out_operand1, out_operand2, out_id
  );

  modport slave (
    input  in_valid, in_fu, in_op, in_w, in_b, in_dest, in_operand1, in_operand2,
           in_dep1, in_dep2, in_tag1, in_tag2, rob_stall, wb_valid, wb_id, wb_value,
           fu_stall, take_branch,
    output in_ready, tail, out_valid, out_fu, out_op, out_w, out_b, out_dest,
           out_operand1, out_operand2, out_id
  );

endinterface

// File: rtl/dispatch_buffer_entry.sv
// One dispatch buffer slot: instruction fields, two operand/pending pairs and
// the tag compare that captures a broadcast result into a waiting operand.
module dispatch_entry
  import dispatch_buffer_pkg::*;
#(
  parameter int unsigned REG_ADDRESS_SIZE = DEF_REG_ADDRESS_SIZE,
  parameter int unsigned REG_SIZE         = DEF_REG_SIZE,
  parameter int unsigned ID_SIZE          = DEF_ID_SIZE,
  parameter int unsigned NUM_FU           = DEF_NUM_FU
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic                        rd_en,
  input  logic                        flush,
  input  logic [NUM_FU-1:0]           wr_fu,
  input  ctrl_t                       wr_ctrl,
  input  logic [REG_ADDRESS_SIZE-1:0] wr_dest,
  input  logic [REG_SIZE-1:0]         wr_op1,
  input  logic [REG_SIZE-1:0]         wr_op2,
  input  logic                        wr_dep1,
  input  logic                        wr_dep2,
  input  logic [ID_SIZE-1:0]          wr_tag1,
  input  logic [ID_SIZE-1:0]          wr_tag2,
  input  logic [ID_SIZE-1:0]          wr_id,
  input  logic                        wb_valid,
  input  logic [ID_SIZE-1:0]          wb_id,
  input  logic [REG_SIZE-1:0]         wb_value,
  output logic [NUM_FU-1:0]           fu,
  output ctrl_t                       ctrl,
  output logic [REG_ADDRESS_SIZE-1:0] dest,
  output logic [REG_SIZE-1:0]         op1,
  output logic [REG_SIZE-1:0]         op2,
  output logic                        pend1,
  output logic                        pend2,
  output logic [ID_SIZE-1:0]          id
);

  logic                        valid_q, valid_d;
  logic [NUM_FU-1:0]           fu_q, fu_d;
  ctrl_t                       ctrl_q, ctrl_d;
  logic [REG_ADDRESS_SIZE-1:0] dest_q, dest_d;
  logic [REG_SIZE-1:0]         op1_q, op1_d, op2_q, op2_d;
  logic                        pend1_q, pend1_d, pend2_q, pend2_d;
  logic [ID_SIZE-1:0]          tag1_q, tag1_d, tag2_q, tag2_d, id_q, id_d;

  // Load on enqueue (resolving a same-cycle broadcast), otherwise snoop wakeups.
  always_comb begin
    valid_d = valid_q;
    fu_d    = fu_q;
    ctrl_d  = ctrl_q;
    dest_d  = dest_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    pend1_d = pend1_q;
    pend2_d = pend2_q;
    tag1_d  = tag1_q;
    tag2_d  = tag2_q;
    id_d    = id_q;
    if (flush) begin
      valid_d = 1'b0;
      pend1_d = 1'b0;
      pend2_d = 1'b0;
    end else if (wr_en) begin
      valid_d = 1'b1;
      fu_d    = wr_fu;
      ctrl_d  = wr_ctrl;
      dest_d  = wr_dest;
      tag1_d  = wr_tag1;
      tag2_d  = wr_tag2;
      id_d    = wr_id;
      op1_d   = wr_op1;
      pend1_d = wr_dep1;
      op2_d   = wr_op2;
      pend2_d = wr_dep2;
      if (wr_dep1 && wb_valid && (wr_tag1 == wb_id)) begin
        op1_d   = wb_value;
        pend1_d = 1'b0;
      end
      if (wr_dep2 && wb_valid && (wr_tag2 == wb_id)) begin
        op2_d   = wb_value;
        pend2_d = 1'b0;
      end
    end else begin
      if (rd_en) valid_d = 1'b0;
      if (valid_q && pend1_q && wb_valid && (tag1_q == wb_id)) begin
        op1_d   = wb_value;
        pend1_d = 1'b0;
      end
      if (valid_q && pend2_q && wb_valid && (tag2_q == wb_id)) begin
        op2_d   = wb_value;
        pend2_d = 1'b0;
      end
    end
  end

  // Slot state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      fu_q    <= '0;
      ctrl_q  <= '0;
      dest_q  <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      pend1_q <= 1'b0;
      pend2_q <= 1'b0;
      tag1_q  <= '0;
      tag2_q  <= '0;
      id_q    <= '0;
    end else begin
      valid_q <= valid_d;
      fu_q    <= fu_d;
      ctrl_q  <= ctrl_d;
      dest_q  <= dest_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      pend1_q <= pend1_d;
      pend2_q <= pend2_d;
      tag1_q  <= tag1_d;
      tag2_q  <= tag2_d;
      id_q    <= id_d;
    end
  end

  assign fu    = fu_q;
  assign ctrl  = ctrl_q;
  assign dest  = dest_q;
  assign op1   = op1_q;
  assign op2   = op2_q;
  assign pend1 = pend1_q;
  assign pend2 = pend2_q;
  assign id    = id_q;

endmodule

// File: rtl/dispatch_buffer.sv
// In-order dispatch buffer: allocates ROB IDs, holds instructions until their
// operands are ready and issues the head entry to its functional unit.
module dispatch_buffer
  import dispatch_buffer_pkg::*;
#(
  parameter int unsigned REG_ADDRESS_SIZE = DEF_REG_ADDRESS_SIZE,
  parameter int unsigned REG_SIZE         = DEF_REG_SIZE,
  parameter int unsigned ID_SIZE          = DEF_ID_SIZE,
  parameter int unsigned DEPTH            = DEF_DEPTH,
  parameter int unsigned NUM_FU           = DEF_NUM_FU
) (
  input logic         clk,
  input logic         reset,
  dispatch_buffer_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]      head_q, head_d, wptr_q, wptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [ID_SIZE-1:0] tail_q, tail_d;
  logic               accept, issue, empty, full;

  logic [NUM_FU-1:0]           e_fu   [DEPTH];
  ctrl_t                       e_ctrl [DEPTH];
  logic [REG_ADDRESS_SIZE-1:0] e_dest [DEPTH];
  logic [REG_SIZE-1:0]         e_op1  [DEPTH];
  logic [REG_SIZE-1:0]         e_op2  [DEPTH];
  logic                        e_pend1[DEPTH];
  logic                        e_pend2[DEPTH];
  logic [ID_SIZE-1:0]          e_id   [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    dispatch_entry #(
      .REG_ADDRESS_SIZE(REG_ADDRESS_SIZE),
      .REG_SIZE        (REG_SIZE),
      .ID_SIZE         (ID_SIZE),
      .NUM_FU          (NUM_FU)
    ) u_entry (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (accept && (wptr_q == PW'(g))),
      .rd_en   (issue && (head_q == PW'(g))),
      .flush   (bus.take_branch),
      .wr_fu   (bus.in_fu),
      .wr_ctrl ('{op: bus.in_op, w: bus.in_w, b: bus.in_b}),
      .wr_dest (bus.in_dest),
      .wr_op1  (bus.in_operand1),
      .wr_op2  (bus.in_operand2),
      .wr_dep1 (bus.in_dep1),
      .wr_dep2 (bus.in_dep2),
      .wr_tag1 (bus.in_tag1),
      .wr_tag2 (bus.in_tag2),
      .wr_id   (tail_q),
      .wb_valid(bus.wb_valid),
      .wb_id   (bus.wb_id),
      .wb_value(bus.wb_value),
      .fu      (e_fu[g]),
      .ctrl    (e_ctrl[g]),
      .dest    (e_dest[g]),
      .op1     (e_op1[g]),
      .op2     (e_op2[g]),
      .pend1   (e_pend1[g]),
      .pend2   (e_pend2[g]),
      .id      (e_id[g])
    );
  end

  // Handshake, issue decision, head-entry output mux and pointer/count update.
  always_comb begin
    empty  = (count_q == '0);
    full   = (count_q == CW'(DEPTH));
    // reset gates in_ready so it reads 0 for the whole reset assertion
    bus.in_ready = reset && !full && !bus.rob_stall && !bus.take_branch;
    accept = bus.in_valid && bus.in_ready;
    issue  = !empty && !e_pend1[head_q] && !e_pend2[head_q] &&
             ((e_fu[head_q] & bus.fu_stall) == '0) && !bus.take_branch;

    bus.out_valid    = issue;
    bus.out_fu       = '0;
    bus.out_op       = 1'b0;
    bus.out_w        = 1'b0;
    bus.out_b        = 1'b0;
    bus.out_dest     = '0;
    bus.out_operand1 = '0;
    bus.out_operand2 = '0;
    bus.out_id       = '0;
    if (!empty) begin
      bus.out_fu       = e_fu[head_q];
      bus.out_op       = e_ctrl[head_q].op;
      bus.out_w        = e_ctrl[head_q].w;
      bus.out_b        = e_ctrl[head_q].b;
      bus.out_dest     = e_dest[head_q];
      bus.out_operand1 = e_op1[head_q];
      bus.out_operand2 = e_op2[head_q];
      bus.out_id       = e_id[head_q];
    end
    bus.tail = tail_q;

    head_d  = head_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    tail_d  = tail_q;
    if (bus.take_branch) begin
      head_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (issue)  head_d = head_q + PW'(1);
      if (accept) begin
        wptr_d = wptr_q + PW'(1);
        tail_d = tail_q + ID_SIZE'(1);
      end
      if (accept && !issue)      count_d = count_q + CW'(1);
      else if (!accept && issue) count_d = count_q - CW'(1);
    end
  end

  // Pointer, occupancy and ROB tail registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      tail_q  <= '0;
    end else begin
      head_q  <= head_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: tb/tb_dispatch_buffer.sv
// Bench for dispatch_buffer: directed scenarios with literal expectations plus
// a randomized run, all checked every cycle against a queue-based model.
module tb_dispatch_buffer;

  localparam int RA = 5, RS = 32, IDS = 4, D = 4, NF = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dispatch_buffer_if #(.REG_ADDRESS_SIZE(RA), .REG_SIZE(RS), .ID_SIZE(IDS), .NUM_FU(NF)) bus();

  dispatch_buffer #(.REG_ADDRESS_SIZE(RA), .REG_SIZE(RS), .ID_SIZE(IDS), .DEPTH(D), .NUM_FU(NF)) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic valid; logic [NF-1:0] fu; logic op, w, b; logic [RA-1:0] dest;
    logic [RS-1:0] o1, o2; logic d1, d2; logic [IDS-1:0] t1, t2;
    logic rob_stall, wb_valid; logic [IDS-1:0] wb_id; logic [RS-1:0] wb_value;
    logic [NF-1:0] fu_stall; logic tb;
  } drv_t;

  typedef struct {
    logic [NF-1:0] fu; logic op, w, b; logic [RA-1:0] dest;
    logic [RS-1:0] v1, v2; logic p1, p2; logic [IDS-1:0] t1, t2, id;
  } ment_t;

  ment_t mq[$];
  logic [IDS-1:0] m_tail = '0;
  int total = 0;
  int bad = 0;

  logic obs_ready, obs_ov;
  logic [IDS-1:0] obs_tail, obs_id;
  logic [RS-1:0] obs_o1, obs_o2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic drv_t idle();
    drv_t d;
    d = '{default: '0};
    return d;
  endfunction

  function automatic drv_t mk(input logic [NF-1:0] fu, input logic [RS-1:0] a, input logic [RS-1:0] b,
                              input logic dp1, input logic [IDS-1:0] tg1,
                              input logic dp2, input logic [IDS-1:0] tg2);
    drv_t d;
    d = idle();
    d.valid = 1'b1; d.fu = fu; d.op = 1'b1; d.w = 1'b1; d.b = 1'b0; d.dest = 5'd3;
    d.o1 = a; d.o2 = b; d.d1 = dp1; d.t1 = tg1; d.d2 = dp2; d.t2 = tg2;
    return d;
  endfunction

  task automatic apply(input drv_t d);
    bus.in_valid = d.valid; bus.in_fu = d.fu; bus.in_op = d.op; bus.in_w = d.w; bus.in_b = d.b;
    bus.in_dest = d.dest; bus.in_operand1 = d.o1; bus.in_operand2 = d.o2;
    bus.in_dep1 = d.d1; bus.in_dep2 = d.d2; bus.in_tag1 = d.t1; bus.in_tag2 = d.t2;
    bus.rob_stall = d.rob_stall; bus.wb_valid = d.wb_valid; bus.wb_id = d.wb_id;
    bus.wb_value = d.wb_value; bus.fu_stall = d.fu_stall; bus.take_branch = d.tb;
  endtask

  // One clock cycle: drive at the falling edge, compare against the model,
  // then advance the model to what the next rising edge must produce.
  task automatic step(input drv_t d);
    logic exp_ready, exp_ov, hv;
    ment_t h, e;
    @(negedge clk);
    apply(d);
    #1;
    hv = (mq.size() > 0);
    h = hv ? mq[0] : '{default: '0};
    exp_ready = (mq.size() < D) && !d.rob_stall && !d.tb;
    exp_ov = hv && !h.p1 && !h.p2 && ((h.fu & d.fu_stall) == '0) && !d.tb;
    chk("in_ready", bus.in_ready, exp_ready);
    chk("out_valid", bus.out_valid, exp_ov);
    chk("tail", bus.tail, m_tail);
    chk("out_fu", bus.out_fu, h.fu);
    chk("out_ctrl", {bus.out_op, bus.out_w, bus.out_b}, {h.op, h.w, h.b});
    chk("out_dest", bus.out_dest, h.dest);
    chk("out_id", bus.out_id, h.id);
    if (exp_ov || !hv) begin
      chk("out_operand1", bus.out_operand1, h.v1);
      chk("out_operand2", bus.out_operand2, h.v2);
    end
    obs_ready = bus.in_ready; obs_ov = bus.out_valid; obs_tail = bus.tail;
    obs_id = bus.out_id; obs_o1 = bus.out_operand1; obs_o2 = bus.out_operand2;

    if (d.tb) begin
      mq.delete();
    end else begin
      for (int i = 0; i < mq.size(); i++) begin
        e = mq[i];
        if (d.wb_valid && e.p1 && e.t1 == d.wb_id) begin e.v1 = d.wb_value; e.p1 = 1'b0; end
        if (d.wb_valid && e.p2 && e.t2 == d.wb_id) begin e.v2 = d.wb_value; e.p2 = 1'b0; end
        mq[i] = e;
      end
      if (exp_ov) void'(mq.pop_front());
      if (d.valid && exp_ready) begin
        e.fu = d.fu; e.op = d.op; e.w = d.w; e.b = d.b; e.dest = d.dest;
        e.t1 = d.t1; e.t2 = d.t2; e.id = m_tail;
        e.v1 = d.o1; e.p1 = d.d1; e.v2 = d.o2; e.p2 = d.d2;
        if (d.wb_valid && d.d1 && d.t1 == d.wb_id) begin e.v1 = d.wb_value; e.p1 = 1'b0; end
        if (d.wb_valid && d.d2 && d.t2 == d.wb_id) begin e.v2 = d.wb_value; e.p2 = 1'b0; end
        mq.push_back(e);
        m_tail = m_tail + 1'b1;
      end
    end
  endtask

  // Assert reset between edges and check the outputs drop immediately.
  task automatic do_reset();
    @(negedge clk);
    apply(idle());
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_tail", bus.tail, 4'd0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    mq.delete();
    m_tail = '0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    drv_t d;
    apply(idle());
    do_reset();

    // no dependencies: operands 5,7
    step(idle());
    chk("post_rst_ready", obs_ready, 1'b1);
    chk("post_rst_tail", obs_tail, 4'd0);
    step(mk(3'b001, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0));
    step(idle());
    chk("nodep_valid", obs_ov, 1'b1);
    chk("nodep_op1", obs_o1, 32'd5);
    chk("nodep_op2", obs_o2, 32'd7);
    chk("nodep_id", obs_id, 4'd0);
    chk("nodep_tail", obs_tail, 4'd1);

    // wakeup of operand 2 via tag 3
    step(mk(3'b001, 32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd3));
    step(idle());
    chk("wake_wait", obs_ov, 1'b0);
    d = idle(); d.wb_valid = 1'b1; d.wb_id = 4'd3; d.wb_value = 32'h2A;
    step(d);
    chk("wake_no_fwd", obs_ov, 1'b0);
    step(idle());
    chk("wake_valid", obs_ov, 1'b1);
    chk("wake_op2", obs_o2, 32'h2A);
    chk("wake_id", obs_id, 4'd1);

    // same-cycle broadcast and enqueue
    d = mk(3'b001, 32'd0, 32'd4, 1'b1, 4'd5, 1'b0, 4'd0);
    d.wb_valid = 1'b1; d.wb_id = 4'd5; d.wb_value = 32'h99;
    step(d);
    step(idle());
    chk("same_valid", obs_ov, 1'b1);
    chk("same_op1", obs_o1, 32'h99);
    chk("same_id", obs_id, 4'd2);

    // reset with three buffered entries
    for (int i = 0; i < 3; i++) begin
      d = mk(3'b001, i, i, 1'b0, 4'd0, 1'b0, 4'd0); d.fu_stall = 3'b111;
      step(d);
    end
    do_reset();
    step(idle());
    chk("rel_ready", obs_ready, 1'b1);

    // fill with stalled MUL ops, then drain in order
    for (int i = 0; i < 4; i++) begin
      d = mk(3'b010, i, i + 10, 1'b0, 4'd0, 1'b0, 4'd0); d.fu_stall = 3'b010;
      step(d);
    end
    d = mk(3'b010, 32'd9, 32'd9, 1'b0, 4'd0, 1'b0, 4'd0); d.fu_stall = 3'b010;
    step(d);
    chk("full_ready", obs_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(idle());
      chk("drain_valid", obs_ov, 1'b1);
      chk("drain_id", obs_id, i);
    end

    // flush with two buffered entries
    for (int i = 0; i < 2; i++) begin
      d = mk(3'b001, i, i, 1'b0, 4'd0, 1'b0, 4'd0); d.fu_stall = 3'b001;
      step(d);
    end
    d = idle(); d.tb = 1'b1;
    step(d);
    chk("flush_valid", obs_ov, 1'b0);
    chk("flush_ready", obs_ready, 1'b0);
    step(idle());
    chk("flush_empty", obs_ov, 1'b0);
    step(mk(3'b100, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0));
    chk("flush_tail_held", obs_tail, 4'd6);
    step(idle());
    chk("flush_next_id", obs_id, 4'd6);

    // ROB ID wrap
    for (int i = 0; i < 16; i++) begin
      step(mk(3'b001, i, i, 1'b0, 4'd0, 1'b0, 4'd0));
      chk("wrap_tail", obs_tail, (7 + i) % 16);
    end
    step(idle());
    chk("wrap_end", obs_tail, 4'd7);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      d = idle();
      d.valid = ($urandom_range(0, 9) < 7);
      d.fu = 3'b001 << $urandom_range(0, 2);
      d.op = 1'($urandom); d.w = 1'($urandom); d.b = 1'($urandom);
      d.dest = 5'($urandom); d.o1 = $urandom; d.o2 = $urandom;
      d.d1 = ($urandom_range(0, 3) == 0); d.t1 = 4'($urandom);
      d.d2 = ($urandom_range(0, 3) == 0); d.t2 = 4'($urandom);
      d.rob_stall = ($urandom_range(0, 9) == 0);
      d.wb_valid = ($urandom_range(0, 1) == 0); d.wb_id = 4'($urandom); d.wb_value = $urandom;
      d.fu_stall = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      d.tb = ($urandom_range(0, 39) == 0);
      step(d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
